instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage directly downstream of the program counter register. Reads pc_in,
//  issues one instruction read per request on the memory handshake bus, and holds
//  returned words in a 2-entry buffer for decode (valid/ready). Drives the PC load
//  interface: sequential increment after each fetch, or a branch redirect target.
// PARAMETERS
//  AddrWidth   24  PC / memory address width
//  DataWidth   32  instruction word width
//  InstrBytes  4   PC increment per fetched instruction
// PORTS
//  clock        in   1          single clock; all state updates on posedge
//  reset        in   1          asynchronous, active-high; clears all state
//  run          in   1          1 = fetch enabled; 0 = no new requests
//  pc_in        in   AddrWidth  current PC value from PC register
//  pc_load_en   out  1          1-cycle pulse: PC register loads pc_next
//  pc_next      out  AddrWidth  next PC value (increment or redirect target)
//  mem_req      out  1          read request, held until mem_ack
//  mem_addr     out  AddrWidth  read address, stable while mem_req=1
//  mem_ack      in   1          read data valid this cycle, ends request
//  mem_data     in   DataWidth  read data
//  redirect_en  in   1          branch/jump taken this cycle
//  redirect_pc  in   AddrWidth  redirect target
//  ir_valid     out  1          buffer non-empty
//  ir_data      out  DataWidth  head instruction word
//  ir_pc        out  AddrWidth  address of head instruction
//  ir_ready     in   1          decode pops head when ir_valid & ir_ready
//  fetch_fault  out  1          misaligned redirect (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE; mem_req, pc_load_en, ir_valid, fetch_fault = 0; mem_addr,
//   pc_next, ir_data, ir_pc = 0; buffer count = 0. Reset mid-transaction abandons it.
//  All outputs registered. PC register captures on the falling edge, so a
//   pc_load_en pulse registered at posedge k is visible on pc_in at posedge k+1.
//  FSM states:
//   IDLE : if redirect_en -> load redirect, stay IDLE. Else if run & count<2
//          -> REQ, mem_req=1, mem_addr=pc_in.
//   REQ  : hold mem_req/mem_addr. On mem_ack & !redirect_en: push
//          {mem_data,mem_addr}, pc_next=mem_addr+InstrBytes (modulo 2^AddrWidth,
//          wraps to 0), pc_load_en=1, mem_req=0 -> IDLE. On redirect_en & mem_ack:
//          discard data, pc_next=redirect_pc, pc_load_en=1 -> IDLE. On redirect_en
//          & !mem_ack: pc_next=redirect_pc, pc_load_en=1 -> DRAIN.
//   DRAIN: hold mem_req until mem_ack; data discarded, no PC load -> IDLE.
//          A further redirect_en here updates pc_next, pulses pc_load_en again.
//  Redirect always flushes the buffer in the same cycle (flush beats pop/push).
//  Min throughput: 1 instr per 2 cycles with 0-wait memory (ack in REQ's 1st cycle).
//  Buffer: 2-entry FIFO; push only from REQ ack; count never exceeds 2 (at most one
//   request outstanding; issue requires count<2). Simultaneous push+pop legal.
//  run=0: outstanding request completes normally, no new issue.
//  pc_load_en deasserts the cycle after any pulse unless a new load event occurs.
// CONFIGURATION
//  ALIGN_CHECK_EN defined: redirect_pc with low log2(InstrBytes) bits nonzero sets
//   fetch_fault (sticky until reset), flushes buffer, no PC load, FSM finishes any
//   outstanding request then parks in IDLE and issues nothing further.
//  Not defined: fetch_fault tied 0; redirect_pc used unmodified.
// STRUCTURE
//  fetch_defs.vh (shared include): FSM state encodings (IDLE/REQ/DRAIN), default
//   widths, INSTR_BYTES constant; reused by decode-side blocks.
//  Sub-module fetch_buf: 2-entry FIFO of {addr,data}, push/pop/flush, count,
//   async reset. FSM and PC-next logic stay in instr_fetch_unit.
// TESTING
//  Reset then run=1, pc_in=0, 0-wait ack: mem_addr 0,4,8; pc_next 4,8,C; ir_pc order 0,4,8.
//  ir_ready=0 with 0-wait memory: exactly 2 fetches, mem_req stays 0, count=2; ir_ready=1 resumes.
//  Redirect to 0x100 while REQ pending, ack 3 cycles later: DRAIN, data dropped,
//   pc_next=0x100, next mem_addr=0x100, buffer empty.
//  pc_in=0xFFFFFC fetched: pc_next=0x000000, pc_load_en pulse 1 cycle.
//  Assert reset during REQ: all outputs 0 immediately, buffer empty, IDLE after release.
//  ALIGN_CHECK_EN: redirect_pc=0x102 -> fetch_fault=1, no further mem_req until reset.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-side definitions: default widths, PC increment and FSM state
// encoding. Imported by the fetch unit and by decode-side blocks that need to
// interpret fetch state.
package instr_fetch_unit_pkg;

  localparam int unsigned ADDR_WIDTH  = 24;
  localparam int unsigned DATA_WIDTH  = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_fetch_buf.sv
// fetch_buf: 2-entry FIFO of {addr, data} feeding decode.
// Ports:
//   clock, reset       : clock, asynchronous active-high reset
//   i_push, i_push_*   : write one {addr, data} entry
//   i_pop              : remove head entry
//   i_flush            : empty the buffer (wins over push/pop)
//   o_count            : number of valid entries (0..2)
//   o_valid            : buffer non-empty
//   o_head_addr/_data  : head entry
module fetch_buf #(
  parameter int unsigned AddrWidth = 24,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_push,
  input  logic [AddrWidth-1:0] i_push_addr,
  input  logic [DataWidth-1:0] i_push_data,
  input  logic                 i_pop,
  input  logic                 i_flush,
  output logic [1:0]           o_count,
  output logic                 o_valid,
  output logic [AddrWidth-1:0] o_head_addr,
  output logic [DataWidth-1:0] o_head_data
);

  logic [AddrWidth-1:0] r_addr [2];
  logic [DataWidth-1:0] r_data [2];
  logic [1:0]           r_count;
  logic                 w_push;
  logic                 w_pop;

  // Slot 0 is always the head; a pop shifts slot 1 down.
  assign w_push = i_push & (r_count != 2'd2);
  assign w_pop  = i_pop  & (r_count != 2'd0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count   <= '0;
      r_addr[0] <= '0;
      r_addr[1] <= '0;
      r_data[0] <= '0;
      r_data[1] <= '0;
    end else if (i_flush) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_addr[0] <= i_push_addr;
            r_data[0] <= i_push_data;
          end else begin
            r_addr[1] <= i_push_addr;
            r_data[1] <= i_push_data;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_addr[0] <= r_addr[1];
          r_data[0] <= r_data[1];
          r_count   <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_addr[0] <= i_push_addr;
            r_data[0] <= i_push_data;
          end else begin
            r_addr[0] <= r_addr[1];
            r_data[0] <= r_data[1];
            r_addr[1] <= i_push_addr;
            r_data[1] <= i_push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_count     = r_count;
  assign o_valid     = (r_count != 2'd0);
  assign o_head_addr = r_addr[0];
  assign o_head_data = r_data[0];

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage downstream of the PC register. Issues one read
// per request on the mem handshake, buffers returned words (2 entries) for
// decode and drives the PC load interface (increment or redirect target).
// Ports: clock/reset (async, active-high); run; pc_in; pc_load_en/pc_next;
//   mem_req/mem_addr/mem_ack/mem_data; redirect_en/redirect_pc;
//   ir_valid/ir_data/ir_pc/ir_ready; fetch_fault.
// Build option: ALIGN_CHECK_EN -- a misaligned redirect sets a sticky
//   fetch_fault and halts further fetching; otherwise fetch_fault is 0.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned AddrWidth  = ADDR_WIDTH,
  parameter int unsigned DataWidth  = DATA_WIDTH,
  parameter int unsigned InstrBytes = INSTR_BYTES
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 run,
  input  logic [AddrWidth-1:0] pc_in,
  output logic                 pc_load_en,
  output logic [AddrWidth-1:0] pc_next,
  output logic                 mem_req,
  output logic [AddrWidth-1:0] mem_addr,
  input  logic                 mem_ack,
  input  logic [DataWidth-1:0] mem_data,
  input  logic                 redirect_en,
  input  logic [AddrWidth-1:0] redirect_pc,
  output logic                 ir_valid,
  output logic [DataWidth-1:0] ir_data,
  output logic [AddrWidth-1:0] ir_pc,
  input  logic                 ir_ready,
  output logic                 fetch_fault
);

  fetch_state_e         r_state, w_state_nxt;
  logic                 r_mem_req, w_mem_req_nxt;
  logic [AddrWidth-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [AddrWidth-1:0] r_pc_next, w_pc_next_nxt;
  logic                 r_pc_load_en, w_pc_load_en_nxt;
  logic                 r_fault, w_fault_nxt;
  logic                 w_push, w_pop, w_flush;
  logic                 w_misaligned;
  logic [1:0]           w_count;

`ifdef ALIGN_CHECK_EN
  assign w_misaligned = |(redirect_pc & AddrWidth'(InstrBytes - 1));
  assign fetch_fault  = r_fault;
`else
  assign w_misaligned = 1'b0;
  assign fetch_fault  = 1'b0;
`endif

  assign w_flush = redirect_en;
  assign w_pop   = ir_valid & ir_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_pc_next    <= '0;
      r_pc_load_en <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_mem_req    <= w_mem_req_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_pc_next    <= w_pc_next_nxt;
      r_pc_load_en <= w_pc_load_en_nxt;
      r_fault      <= w_fault_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_mem_req_nxt    = r_mem_req;
    w_mem_addr_nxt   = r_mem_addr;
    w_pc_next_nxt    = r_pc_next;
    w_pc_load_en_nxt = 1'b0;
    w_fault_nxt      = r_fault;
    w_push           = 1'b0;

    // Redirect loads the PC from any state; a misaligned one faults instead.
    if (redirect_en) begin
      if (w_misaligned) begin
        w_fault_nxt = 1'b1;
      end else begin
        w_pc_next_nxt    = redirect_pc;
        w_pc_load_en_nxt = 1'b1;
      end
    end

    case (r_state)
      ST_IDLE: begin
        if (!redirect_en && run && (w_count < 2'd2) && !r_fault) begin
          w_state_nxt    = ST_REQ;
          w_mem_req_nxt  = 1'b1;
          w_mem_addr_nxt = pc_in;
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          w_state_nxt   = ST_IDLE;
          w_mem_req_nxt = 1'b0;
          if (!redirect_en) begin
            w_push           = 1'b1;
            w_pc_next_nxt    = r_mem_addr + AddrWidth'(InstrBytes);
            w_pc_load_en_nxt = 1'b1;
          end
        end else if (redirect_en) begin
          // Request cannot be withdrawn; finish it and drop the data.
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (mem_ack) begin
          w_state_nxt   = ST_IDLE;
          w_mem_req_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_mem_req_nxt = 1'b0;
      end
    endcase
  end

  fetch_buf #(
    .AddrWidth(AddrWidth),
    .DataWidth(DataWidth)
  ) u_buf (
    .clock       (clock),
    .reset       (reset),
    .i_push      (w_push),
    .i_push_addr (r_mem_addr),
    .i_push_data (mem_data),
    .i_pop       (w_pop),
    .i_flush     (w_flush),
    .o_count     (w_count),
    .o_valid     (ir_valid),
    .o_head_addr (ir_pc),
    .o_head_data (ir_data)
  );

  assign mem_req    = r_mem_req;
  assign mem_addr   = r_mem_addr;
  assign pc_next    = r_pc_next;
  assign pc_load_en = r_pc_load_en;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic        clock;
  logic        reset;
  logic        run;
  logic [23:0] pc_in;
  logic        pc_load_en;
  logic [23:0] pc_next;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic        redirect_en;
  logic [23:0] redirect_pc;
  logic        ir_valid;
  logic [31:0] ir_data;
  logic [23:0] ir_pc;
  logic        ir_ready;
  logic        fetch_fault;

  int n_chk;
  int n_fail;

  instr_fetch_unit #(
    .AddrWidth (24),
    .DataWidth (32),
    .InstrBytes(4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .run        (run),
    .pc_in      (pc_in),
    .pc_load_en (pc_load_en),
    .pc_next    (pc_next),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .ir_valid   (ir_valid),
    .ir_data    (ir_data),
    .ir_pc      (ir_pc),
    .ir_ready   (ir_ready),
    .fetch_fault(fetch_fault)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // PC register: captures pc_next on the falling edge when pc_load_en is high.
  initial begin
    pc_in = '0;
    forever begin
      @(negedge clock);
      if (reset)           pc_in = '0;
      else if (pc_load_en) pc_in = pc_next;
    end
  end

  typedef struct packed {
    logic        run;
    logic        ack;
    logic [31:0] data;
    logic        redir;
    logic [23:0] rpc;
    logic        ready;
    logic        req;
    logic [23:0] addr;
    logic        load;
    logic [23:0] pcn;
    logic        valid;
    logic [23:0] irpc;
    logic [31:0] irdata;
  } vec_t;

  vec_t tbl [32];

  function automatic vec_t mk(logic r, logic a, logic [31:0] d, logic rd,
                              logic [23:0] rp, logic rdy, logic q,
                              logic [23:0] ad, logic ld, logic [23:0] pn,
                              logic v, logic [23:0] ip, logic [31:0] id);
    vec_t t;
    t.run = r;  t.ack = a;  t.data = d;  t.redir = rd; t.rpc = rp; t.ready = rdy;
    t.req = q;  t.addr = ad; t.load = ld; t.pcn = pn;  t.valid = v;
    t.irpc = ip; t.irdata = id;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic r, input logic a, input logic [31:0] d,
                       input logic rd, input logic [23:0] rp, input logic rdy);
    run = r; mem_ack = a; mem_data = d; redirect_en = rd; redirect_pc = rp; ir_ready = rdy;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset = 1'b1;
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);

    //          run ack data          rd rpc         rdy | req addr       ld pcn         v  irpc        irdata
    tbl[0]  = mk(1, 0, 32'h0,         0, 24'h0,      1,   1, 24'h000000, 0, 24'h000000, 0, 24'h0,      32'h0);
    tbl[1]  = mk(1, 1, 32'hC0DE0000,  0, 24'h0,      1,   0, 24'h000000, 1, 24'h000004, 1, 24'h000000, 32'hC0DE0000);
    tbl[2]  = mk(1, 0, 32'h0,         0, 24'h0,      1,   1, 24'h000004, 0, 24'h000004, 0, 24'h0,      32'h0);
    tbl[3]  = mk(1, 1, 32'hC0DE0001,  0, 24'h0,      1,   0, 24'h000004, 1, 24'h000008, 1, 24'h000004, 32'hC0DE0001);
    tbl[4]  = mk(1, 0, 32'h0,         0, 24'h0,      1,   1, 24'h000008, 0, 24'h000008, 0, 24'h0,      32'h0);
    tbl[5]  = mk(1, 1, 32'hC0DE0002,  0, 24'h0,      1,   0, 24'h000008, 1, 24'h00000C, 1, 24'h000008, 32'hC0DE0002);
    tbl[6]  = mk(0, 0, 32'h0,         0, 24'h0,      0,   0, 24'h000008, 0, 24'h00000C, 1, 24'h000008, 32'hC0DE0002);
    tbl[7]  = mk(0, 0, 32'h0,         1, 24'h000040, 0,   0, 24'h000008, 1, 24'h000040, 0, 24'h0,      32'h0);
    tbl[8]  = mk(1, 0, 32'h0,         0, 24'h0,      0,   1, 24'h000040, 0, 24'h000040, 0, 24'h0,      32'h0);
    tbl[9]  = mk(1, 1, 32'hC0DE0003,  0, 24'h0,      0,   0, 24'h000040, 1, 24'h000044, 1, 24'h000040, 32'hC0DE0003);
    tbl[10] = mk(1, 0, 32'h0,         0, 24'h0,      0,   1, 24'h000044, 0, 24'h000044, 1, 24'h000040, 32'hC0DE0003);
    tbl[11] = mk(1, 1, 32'hC0DE0004,  0, 24'h0,      0,   0, 24'h000044, 1, 24'h000048, 1, 24'h000040, 32'hC0DE0003);
    tbl[12] = mk(1, 0, 32'h0,         0, 24'h0,      0,   0, 24'h000044, 0, 24'h000048, 1, 24'h000040, 32'hC0DE0003);
    tbl[13] = mk(1, 0, 32'h0,         0, 24'h0,      0,   0, 24'h000044, 0, 24'h000048, 1, 24'h000040, 32'hC0DE0003);
    tbl[14] = mk(1, 0, 32'h0,         0, 24'h0,      1,   0, 24'h000044, 0, 24'h000048, 1, 24'h000044, 32'hC0DE0004);
    tbl[15] = mk(1, 0, 32'h0,         0, 24'h0,      0,   1, 24'h000048, 0, 24'h000048, 1, 24'h000044, 32'hC0DE0004);
    tbl[16] = mk(1, 1, 32'hC0DE0005,  0, 24'h0,      0,   0, 24'h000048, 1, 24'h00004C, 1, 24'h000044, 32'hC0DE0004);
    tbl[17] = mk(1, 0, 32'h0,         1, 24'h000200, 0,   0, 24'h000048, 1, 24'h000200, 0, 24'h0,      32'h0);
    tbl[18] = mk(1, 0, 32'h0,         0, 24'h0,      0,   1, 24'h000200, 0, 24'h000200, 0, 24'h0,      32'h0);
    tbl[19] = mk(1, 0, 32'h0,         1, 24'h000100, 0,   1, 24'h000200, 1, 24'h000100, 0, 24'h0,      32'h0);
    tbl[20] = mk(1, 0, 32'h0,         0, 24'h0,      0,   1, 24'h000200, 0, 24'h000100, 0, 24'h0,      32'h0);
    tbl[21] = mk(1, 0, 32'h0,         0, 24'h0,      0,   1, 24'h000200, 0, 24'h000100, 0, 24'h0,      32'h0);
    tbl[22] = mk(1, 1, 32'hDEADBEEF,  0, 24'h0,      0,   0, 24'h000200, 0, 24'h000100, 0, 24'h0,      32'h0);
    tbl[23] = mk(1, 0, 32'h0,         0, 24'h0,      0,   1, 24'h000100, 0, 24'h000100, 0, 24'h0,      32'h0);
    tbl[24] = mk(1, 1, 32'hC0DE0006,  0, 24'h0,      0,   0, 24'h000100, 1, 24'h000104, 1, 24'h000100, 32'hC0DE0006);
    tbl[25] = mk(1, 0, 32'h0,         1, 24'hFFFFFC, 0,   0, 24'h000100, 1, 24'hFFFFFC, 0, 24'h0,      32'h0);
    tbl[26] = mk(1, 0, 32'h0,         0, 24'h0,      0,   1, 24'hFFFFFC, 0, 24'hFFFFFC, 0, 24'h0,      32'h0);
    tbl[27] = mk(1, 1, 32'hC0DE0007,  0, 24'h0,      0,   0, 24'hFFFFFC, 1, 24'h000000, 1, 24'hFFFFFC, 32'hC0DE0007);
    tbl[28] = mk(0, 0, 32'h0,         0, 24'h0,      0,   0, 24'hFFFFFC, 0, 24'h000000, 1, 24'hFFFFFC, 32'hC0DE0007);
    tbl[29] = mk(1, 0, 32'h0,         0, 24'h0,      1,   1, 24'h000000, 0, 24'h000000, 0, 24'h0,      32'h0);
    tbl[30] = mk(1, 1, 32'hC0DE0008,  1, 24'h000080, 0,   0, 24'h000000, 1, 24'h000080, 0, 24'h0,      32'h0);
    tbl[31] = mk(0, 0, 32'h0,         0, 24'h0,      0,   0, 24'h000000, 0, 24'h000080, 0, 24'h0,      32'h0);

    // Reset state
    step();
    step();
    chk("rst mem_req",     32'(mem_req),     32'h0);
    chk("rst mem_addr",    32'(mem_addr),    32'h0);
    chk("rst pc_load_en",  32'(pc_load_en),  32'h0);
    chk("rst pc_next",     32'(pc_next),     32'h0);
    chk("rst ir_valid",    32'(ir_valid),    32'h0);
    chk("rst ir_data",     32'(ir_data),     32'h0);
    chk("rst ir_pc",       32'(ir_pc),       32'h0);
    chk("rst fetch_fault", 32'(fetch_fault), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 32; i++) begin
      drive(tbl[i].run, tbl[i].ack, tbl[i].data, tbl[i].redir, tbl[i].rpc, tbl[i].ready);
      step();
      chk($sformatf("v%0d mem_req", i),     32'(mem_req),     32'(tbl[i].req));
      chk($sformatf("v%0d mem_addr", i),    32'(mem_addr),    32'(tbl[i].addr));
      chk($sformatf("v%0d pc_load_en", i),  32'(pc_load_en),  32'(tbl[i].load));
      chk($sformatf("v%0d pc_next", i),     32'(pc_next),     32'(tbl[i].pcn));
      chk($sformatf("v%0d ir_valid", i),    32'(ir_valid),    32'(tbl[i].valid));
      chk($sformatf("v%0d fetch_fault", i), 32'(fetch_fault), 32'h0);
      if (tbl[i].valid) begin
        chk($sformatf("v%0d ir_pc", i),   32'(ir_pc), 32'(tbl[i].irpc));
        chk($sformatf("v%0d ir_data", i), ir_data,    tbl[i].irdata);
      end
    end

    // Reset asserted while a request is outstanding with a non-empty buffer.
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    step();
    chk("pre-rst issue mem_addr", 32'(mem_addr), 32'h000080);
    drive(1'b1, 1'b1, 32'hC0DE0009, 1'b0, '0, 1'b0);
    step();
    chk("pre-rst ir_pc", 32'(ir_pc), 32'h000080);
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    step();
    chk("pre-rst mem_req", 32'(mem_req), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("async-rst mem_req",    32'(mem_req),    32'h0);
    chk("async-rst mem_addr",   32'(mem_addr),   32'h0);
    chk("async-rst pc_load_en", 32'(pc_load_en), 32'h0);
    chk("async-rst pc_next",    32'(pc_next),    32'h0);
    chk("async-rst ir_valid",   32'(ir_valid),   32'h0);
    chk("async-rst ir_data",    32'(ir_data),    32'h0);
    chk("async-rst ir_pc",      32'(ir_pc),      32'h0);
    step();
    reset = 1'b0;
    step();
    chk("post-rst issue mem_req",  32'(mem_req),  32'h1);
    chk("post-rst issue mem_addr", 32'(mem_addr), 32'h0);

    // Misaligned redirect while a request is outstanding.
    drive(1'b1, 1'b0, '0, 1'b1, 24'h000102, 1'b0);
    step();
`ifdef ALIGN_CHECK_EN
    chk("misalign fetch_fault", 32'(fetch_fault), 32'h1);
    chk("misalign pc_load_en",  32'(pc_load_en),  32'h0);
    chk("misalign drain req",   32'(mem_req),     32'h1);
    drive(1'b1, 1'b1, 32'hBAD0BAD0, 1'b0, '0, 1'b0);
    step();
    chk("misalign drain done", 32'(mem_req),  32'h0);
    chk("misalign ir_valid",   32'(ir_valid), 32'h0);
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("parked%0d mem_req", k),     32'(mem_req),     32'h0);
      chk($sformatf("parked%0d fetch_fault", k), 32'(fetch_fault), 32'h1);
    end
`else
    chk("unaligned fetch_fault", 32'(fetch_fault), 32'h0);
    chk("unaligned pc_load_en",  32'(pc_load_en),  32'h1);
    chk("unaligned pc_next",     32'(pc_next),     32'h000102);
    chk("unaligned drain req",   32'(mem_req),     32'h1);
    drive(1'b1, 1'b1, 32'hBAD0BAD0, 1'b0, '0, 1'b0);
    step();
    chk("unaligned drain done", 32'(mem_req),    32'h0);
    chk("unaligned no load",    32'(pc_load_en), 32'h0);
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    step();
    chk("unaligned issue addr", 32'(mem_addr), 32'h000102);
    drive(1'b1, 1'b1, 32'hC0DE000A, 1'b0, '0, 1'b0);
    step();
    chk("unaligned incr pc_next", 32'(pc_next), 32'h000106);
    chk("unaligned ir_data",      ir_data,      32'hC0DE000A);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
